// File: rtl/pkt_rr_arbiter_pkg.sv
// Shared types and helpers for the packet-locking round-robin arbiter.
package pkt_rr_arbiter_pkg;

  localparam int unsigned REQ_WIDTH_DEF = 4;
  localparam int unsigned DW_DEF        = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Ceiling log2, used for index widths.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/pkt_rr_arbiter_if.sv
// Requester-side and downstream-side channel bundle of the arbiter.
interface pkt_rr_arbiter_if
  import pkt_rr_arbiter_pkg::*;
#(
  parameter int unsigned REQ_WIDTH = REQ_WIDTH_DEF,
  parameter int unsigned DW        = DW_DEF
);

  localparam int unsigned IDW = clog2(REQ_WIDTH);

  logic [REQ_WIDTH-1:0]    valid_in;
  logic [REQ_WIDTH-1:0]    last_in;
  logic [REQ_WIDTH*DW-1:0] data_in;
  logic [REQ_WIDTH-1:0]    ready_out;
  logic                    valid_out;
  logic                    last_out;
  logic [DW-1:0]           data_out;
  logic [IDW-1:0]          id_out;
  logic                    ready_in;
  logic                    busy;

  // Arbiter side.
  modport slave (
    input  valid_in, last_in, data_in, ready_in,
    output ready_out, valid_out, last_out, data_out, id_out, busy
  );

  // Requesters plus downstream consumer side.
  modport master (
    output valid_in, last_in, data_in, ready_in,
    input  ready_out, valid_out, last_out, data_out, id_out, busy
  );

endinterface

// File: rtl/pkt_rr_arbiter_rr_pick.sv
// Round-robin priority pick: requests above ptr win first, otherwise lowest index.
module pkt_rr_arbiter_rr_pick
  import pkt_rr_arbiter_pkg::*;
#(
  parameter int unsigned REQ_WIDTH = REQ_WIDTH_DEF,
  parameter int unsigned IDW       = clog2(REQ_WIDTH)
) (
  input  logic [REQ_WIDTH-1:0] req,
  input  logic [IDW-1:0]       ptr,
  output logic [REQ_WIDTH-1:0] grant,
  output logic [IDW-1:0]       idx
);

  logic [REQ_WIDTH-1:0] mask;
  logic [REQ_WIDTH-1:0] masked;
  logic [REQ_WIDTH-1:0] sel;

  // Masked pick above ptr with fallback to the unmasked pick, lowest index wins.
  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(REQ_WIDTH); i++) mask[i] = (IDW'(i) > ptr);
    masked = req & mask;
    sel    = (|masked) ? masked : req;
    grant  = '0;
    idx    = '0;
    for (int i = int'(REQ_WIDTH) - 1; i >= 0; i--) begin
      if (sel[i]) idx = IDW'(i);
    end
    grant[idx] = |sel;
  end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-locking round-robin arbiter with a registered single-beat output stage.
module pkt_rr_arbiter
  import pkt_rr_arbiter_pkg::*;
#(
  parameter int unsigned REQ_WIDTH = REQ_WIDTH_DEF,
  parameter int unsigned DW        = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  pkt_rr_arbiter_if.slave  bus
);

  localparam int unsigned IDW = clog2(REQ_WIDTH);

  arb_state_t           state_q, state_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [IDW-1:0]       ptr_q, ptr_d;

  logic                 valid_q;
  logic                 last_q;
  logic [DW-1:0]        data_q;
  logic [IDW-1:0]       id_q;

  logic [REQ_WIDTH-1:0] pick_grant;
  logic [IDW-1:0]       pick_idx;
  logic [REQ_WIDTH-1:0] grant;
  logic [REQ_WIDTH-1:0] ready_c;
  logic [IDW-1:0]       sel_idx;
  logic [DW-1:0]        sel_data;
  logic                 sel_last;
  logic                 load;
  logic                 accept;

  pkt_rr_arbiter_rr_pick #(
    .REQ_WIDTH (REQ_WIDTH),
    .IDW       (IDW)
  ) u_pick (
    .req   (bus.valid_in),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Grant selection, handshake, data mux and next-state decode.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    grant    = '0;
    sel_idx  = '0;
    sel_data = '0;
    sel_last = 1'b0;

    load = ~valid_q | bus.ready_in;

    if (state_q == LOCKED) begin
      grant[owner_q] = 1'b1;
      sel_idx        = owner_q;
    end else begin
      grant   = pick_grant;
      sel_idx = pick_idx;
    end

    ready_c = grant & {REQ_WIDTH{load}};
    accept  = |(bus.valid_in & ready_c);

    for (int i = 0; i < int'(REQ_WIDTH); i++) begin
      if (sel_idx == IDW'(i)) begin
        sel_data = bus.data_in[i*DW +: DW];
        sel_last = bus.last_in[i];
      end
    end

    if (accept) begin
      if (state_q == IDLE) begin
        if (sel_last) begin
          ptr_d = sel_idx;
        end else begin
          state_d = LOCKED;
          owner_d = sel_idx;
        end
      end else if (sel_last) begin
        state_d = IDLE;
        ptr_d   = owner_q;
      end
    end
  end

  // FSM, owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= IDW'(REQ_WIDTH - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Output register: load on accept, drop valid when drained with nothing new.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      last_q  <= sel_last;
      data_q  <= sel_data;
      id_q    <= sel_idx;
    end else if (valid_q && bus.ready_in) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.ready_out = ready_c;
  assign bus.valid_out = valid_q;
  assign bus.last_out  = last_q;
  assign bus.data_out  = data_q;
  assign bus.id_out    = id_q;
  assign bus.busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Randomized scoreboard bench for pkt_rr_arbiter against a behavioural arbitration model.
module tb_pkt_rr_arbiter;
  import pkt_rr_arbiter_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 8;
  localparam int unsigned IDW = clog2(N);

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            id;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pkt_rr_arbiter_if #(.REQ_WIDTH(N), .DW(DW)) bus ();

  pkt_rr_arbiter #(.REQ_WIDTH(N), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  beat_t sb[$];
  int    id_log[$];

  // Requester-side state: the beat currently offered and beats left in its packet.
  bit            vld[N];
  logic [DW-1:0] cur_data[N];
  bit            cur_last[N];
  int            remaining[N];

  // Arbitration model: current packet owner (-1 if none), last requester served, output occupancy.
  int owner;
  int last_srv;
  bit m_out_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner       = -1;
    last_srv    = int'(N) - 1;
    m_out_valid = 1'b0;
    for (int r = 0; r < int'(N); r++) begin
      vld[r]       = 1'b0;
      remaining[r] = 0;
      cur_data[r]  = '0;
      cur_last[r]  = 1'b0;
    end
    sb.delete();
  endtask

  task automatic drive_inputs(input int p_valid, input int max_len, input int p_ready);
    logic [N-1:0]    v;
    logic [N-1:0]    l;
    logic [N*DW-1:0] d;
    for (int r = 0; r < int'(N); r++) begin
      if (!vld[r] && int'($urandom_range(99)) < p_valid) begin
        if (remaining[r] == 0) remaining[r] = int'($urandom_range(max_len, 1));
        cur_data[r] = DW'($urandom);
        cur_last[r] = (remaining[r] == 1);
        vld[r]      = 1'b1;
      end
      v[r]          = vld[r];
      l[r]          = cur_last[r];
      d[r*DW +: DW] = cur_data[r];
    end
    bus.valid_in = v;
    bus.last_in  = l;
    bus.data_in  = d;
    bus.ready_in = (int'($urandom_range(99)) < p_ready);
  endtask

  // One cycle of the reference: who may send, whether a beat moves, and its effect.
  task automatic model_step();
    int           cand;
    bit           load;
    logic [N-1:0] exp_ready;
    beat_t        b;
    chk("busy", 64'(bus.busy), 64'(owner >= 0));
    chk("valid_out", 64'(bus.valid_out), 64'(m_out_valid));
    load = !m_out_valid || bus.ready_in;
    cand = -1;
    if (owner >= 0) begin
      cand = owner;
    end else begin
      for (int j = 1; j <= int'(N); j++) begin
        int r;
        r = (last_srv + j) % int'(N);
        if (cand < 0 && vld[r]) cand = r;
      end
    end
    exp_ready = '0;
    if (cand >= 0 && load) exp_ready[cand] = 1'b1;
    chk("ready_out", 64'(bus.ready_out), 64'(exp_ready));
    if (cand >= 0 && load && vld[cand]) begin
      b.data = cur_data[cand];
      b.last = cur_last[cand];
      b.id   = cand;
      sb.push_back(b);
      vld[cand] = 1'b0;
      remaining[cand]--;
      if (cur_last[cand]) begin
        owner    = -1;
        last_srv = cand;
      end else begin
        owner = cand;
      end
      m_out_valid = 1'b1;
    end else if (m_out_valid && bus.ready_in) begin
      m_out_valid = 1'b0;
    end
  endtask

  task automatic run(input int n, input int p_valid, input int max_len, input int p_ready);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive_inputs(p_valid, max_len, p_ready);
      @(negedge clk);
      model_step();
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.valid_in = '0;
    bus.last_in  = '0;
    bus.data_in  = '0;
    bus.ready_in = 1'b1;
    model_reset();
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid_out", 64'(bus.valid_out), 64'(0));
    chk("rst_last_out", 64'(bus.last_out), 64'(0));
    chk("rst_data_out", 64'(bus.data_out), 64'(0));
    chk("rst_id_out", 64'(bus.id_out), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_ready_out", 64'(bus.ready_out), 64'(0));
  endtask

  // Monitor: every presented beat must match the oldest accepted beat; pop when drained.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.valid_out) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got id %0d data %0h with nothing expected", bus.id_out, bus.data_out);
        end else begin
          chk("data_out", 64'(bus.data_out), 64'(sb[0].data));
          chk("last_out", 64'(bus.last_out), 64'(sb[0].last));
          chk("id_out", 64'(bus.id_out), 64'(sb[0].id));
          if (bus.ready_in) begin
            id_log.push_back(sb[0].id);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int order[5];
    rst          = 1'b1;
    bus.valid_in = '0;
    bus.last_in  = '0;
    bus.data_in  = '0;
    bus.ready_in = 1'b0;
    model_reset();
    apply_reset(2);

    // All requesters valid with single-beat packets: fair rotation from requester 0.
    id_log.delete();
    run(7, 100, 1, 100);
    order = '{0, 1, 2, 3, 0};
    chk("order_count", 64'(id_log.size() >= 5), 64'(1));
    if (id_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("order_%0d", i), 64'(id_log[i]), 64'(order[i]));
    end

    // Multi-beat packets, full throughput, then sustained backpressure and release.
    run(40, 100, 4, 100);
    run(6, 100, 4, 0);
    run(20, 100, 4, 100);

    // Sparse requesters with bubbles and random backpressure.
    run(300, 35, 4, 70);
    run(300, 80, 3, 50);

    // Reset in the middle of a locked packet, then restart from requester 0.
    begin
      int k;
      k = 0;
      while (owner < 0 && k < 500) begin
        run(1, 100, 4, 100);
        k++;
      end
      chk("lock_reached", 64'(owner >= 0), 64'(1));
    end
    apply_reset(1);
    run(1, 100, 1, 100);
    run(200, 60, 4, 80);

    // Drain everything that was accepted.
    run(20, 0, 1, 100);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
